// File: rtl/conv_job_sched_if.sv
// Job handshake between conv_job_sched (master) and the convolution engine (slave).
// A job transfers on fire = job_valid & job_ready; once job_valid rises, it and every job_* field hold until fire.
interface conv_job_sched_if;
  logic       job_valid;
  logic       job_ready;
  logic       job_layer;
  logic [3:0] job_oc;
  logic [4:0] job_row;
  logic [2:0] job_ic;
  logic       job_first_ic;
  logic       job_last_ic;
  logic       job_done;

  modport master (
    output job_valid, job_layer, job_oc, job_row, job_ic, job_first_ic, job_last_ic,
    input  job_ready, job_done
  );

  modport slave (
    input  job_valid, job_layer, job_oc, job_row, job_ic, job_first_ic, job_last_ic,
    output job_ready, job_done
  );
endinterface

// File: rtl/conv_job_sched.sv
// Row-job sequencer for the shared conv engine: walks CONV1 then CONV2 as (oc, row, ic) jobs.
// Optional CONV_JOB_SCHED_PERF_EN adds stall_cycles / run_cycles counters.
module conv_job_sched #(
  parameter int L1_OC   = 6,
  parameter int L1_IC   = 1,
  parameter int L1_ROWS = 24,
  parameter int L2_OC   = 16,
  parameter int L2_IC   = 6,
  parameter int L2_ROWS = 8,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              conv_start,
  conv_job_sched_if.master  job,
  output logic              conv1_done,
  output logic              conv_done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
`ifdef CONV_JOB_SCHED_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       run_cycles
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] L1_OC_MAX   = 4'(L1_OC - 1);
  localparam logic [4:0] L1_ROW_MAX  = 5'(L1_ROWS - 1);
  localparam logic [2:0] L1_IC_MAX   = 3'(L1_IC - 1);
  localparam logic [3:0] L2_OC_MAX   = 4'(L2_OC - 1);
  localparam logic [4:0] L2_ROW_MAX  = 5'(L2_ROWS - 1);
  localparam logic [2:0] L2_IC_MAX   = 3'(L2_IC - 1);
  localparam logic [2:0] MAX_OUT_V   = 3'(MAX_OUT);

  state_t     state;
  logic       layer;
  logic [3:0] oc;
  logic [4:0] row;
  logic [2:0] ic;
  logic       valid;
  logic [2:0] outst;

  logic [3:0] oc_max;
  logic [4:0] row_max;
  logic [2:0] ic_max;
  logic       fire;
  logic       done_ok;
  logic       last_job;
  logic [2:0] outst_next;

  always_comb begin
    oc_max  = layer ? L2_OC_MAX  : L1_OC_MAX;
    row_max = layer ? L2_ROW_MAX : L1_ROW_MAX;
    ic_max  = layer ? L2_IC_MAX  : L1_IC_MAX;
  end

  assign fire     = valid & job.job_ready;
  // A completion with nothing in flight is an engine protocol error, never a count change.
  assign done_ok  = job.job_done & (outst != 3'd0);
  assign last_job = (ic == ic_max) && (row == row_max) && (oc == oc_max);

  always_comb begin
    outst_next = outst;
    if (fire && !done_ok)      outst_next = outst + 3'd1;
    else if (!fire && done_ok) outst_next = outst - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state      <= IDLE;
      layer      <= 1'b0;
      oc         <= 4'd0;
      row        <= 5'd0;
      ic         <= 3'd0;
      valid      <= 1'b0;
      outst      <= 3'd0;
      conv1_done <= 1'b0;
      conv_done  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      conv1_done <= 1'b0;
      conv_done  <= 1'b0;
      outst      <= outst_next;
      if (job.job_done && outst == 3'd0) err <= 1'b1;

      // ic innermost, then row, then oc; the final job wraps everything back to zero.
      if (fire) begin
        if (ic != ic_max) begin
          ic <= ic + 3'd1;
        end else begin
          ic <= 3'd0;
          if (row != row_max) begin
            row <= row + 5'd1;
          end else begin
            row <= 5'd0;
            oc  <= (oc != oc_max) ? oc + 4'd1 : 4'd0;
          end
        end
      end

      case (state)
        IDLE: begin
          if (conv_start) begin
            state <= ISSUE;
            layer <= 1'b0;
            oc    <= 4'd0;
            row   <= 5'd0;
            ic    <= 3'd0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (fire && last_job) begin
            state <= DRAIN;
            valid <= 1'b0;
          end else if (!valid || fire) begin
            // A presented job is never withdrawn; only re-evaluate when none is pending.
            valid <= (outst_next < MAX_OUT_V);
          end
        end
        DRAIN: begin
          if (outst_next == 3'd0) begin
            if (!layer) begin
              state      <= ISSUE;
              layer      <= 1'b1;
              oc         <= 4'd0;
              row        <= 5'd0;
              ic         <= 3'd0;
              conv1_done <= 1'b1;
            end else begin
              state     <= DONE;
              conv_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign job.job_valid    = valid;
  assign job.job_layer    = layer;
  assign job.job_oc       = oc;
  assign job.job_row      = row;
  assign job.job_ic       = ic;
  assign job.job_first_ic = valid & (ic == 3'd0);
  assign job.job_last_ic  = valid & (ic == ic_max);
  assign state_dbg        = state;

`ifdef CONV_JOB_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!srstn) begin
      stall_cycles <= 16'd0;
      run_cycles   <= 16'd0;
    end else if (state == IDLE && conv_start) begin
      stall_cycles <= 16'd0;
      run_cycles   <= 16'd0;
    end else begin
      if (valid && !job.job_ready && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (busy && run_cycles != 16'hFFFF)                      run_cycles   <= run_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_job_sched.sv
// Bench for conv_job_sched: a default-parameter instance driven against a queue-based job model,
// and a small instance for ordering vectors and the outstanding-limit sequence.
module tb_conv_job_sched;

  localparam int A_N1 = 6 * 24 * 1;
  localparam int A_N2 = 16 * 8 * 6;
  localparam int A_MAXOUT = 2;

  typedef struct {
    int          stall;
    logic [14:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: default parameters ----------------
  conv_job_sched_if a_if ();
  logic       a_srstn, a_start, a_c1, a_cd, a_busy, a_err;
  logic [1:0] a_state;
`ifdef CONV_JOB_SCHED_PERF_EN
  logic [15:0] a_stall, a_run;
`endif

  conv_job_sched #(
    .L1_OC(6), .L1_IC(1), .L1_ROWS(24), .L2_OC(16), .L2_IC(6), .L2_ROWS(8), .MAX_OUT(A_MAXOUT)
  ) dut_a (
    .clk(clk), .srstn(a_srstn), .conv_start(a_start), .job(a_if),
`ifdef CONV_JOB_SCHED_PERF_EN
    .stall_cycles(a_stall), .run_cycles(a_run),
`endif
    .conv1_done(a_c1), .conv_done(a_cd), .busy(a_busy), .err(a_err), .state_dbg(a_state)
  );

  // ---------------- instance B: tiny layers ----------------
  conv_job_sched_if b_if ();
  logic       b_srstn, b_start, b_c1, b_cd, b_busy, b_err;
  logic [1:0] b_state;
`ifdef CONV_JOB_SCHED_PERF_EN
  logic [15:0] b_stall, b_run;
`endif

  conv_job_sched #(
    .L1_OC(2), .L1_IC(2), .L1_ROWS(2), .L2_OC(2), .L2_IC(3), .L2_ROWS(1), .MAX_OUT(2)
  ) dut_b (
    .clk(clk), .srstn(b_srstn), .conv_start(b_start), .job(b_if),
`ifdef CONV_JOB_SCHED_PERF_EN
    .stall_cycles(b_stall), .run_cycles(b_run),
`endif
    .conv1_done(b_c1), .conv_done(b_cd), .busy(b_busy), .err(b_err), .state_dbg(b_state)
  );

  // ---------------- scoreboard state ----------------
  int n_pass = 0, n_total = 0;
  int cyc = 0;
  logic [14:0] exp_q[$];
  int pend_q[$];
  int out_cnt, done_total, exp_c1, exp_cd, fire_cnt, l0_fires, l1_fires, n_c1, n_cd, last_due;
  bit hold_prev, start_req, spur_req, seen_cd, stall_arm, midstart_done;
  int stall_left;
  logic [14:0] prev_job;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [14:0] a_job();
    return {a_if.job_layer, a_if.job_oc, a_if.job_row, a_if.job_ic, a_if.job_first_ic, a_if.job_last_ic};
  endfunction

  function automatic logic [14:0] b_job();
    return {b_if.job_layer, b_if.job_oc, b_if.job_row, b_if.job_ic, b_if.job_first_ic, b_if.job_last_ic};
  endfunction

  function automatic logic [21:0] outs_a();
    return {a_if.job_valid, a_job(), a_c1, a_cd, a_busy, a_err, a_state};
  endfunction

  function automatic logic [21:0] outs_b();
    return {b_if.job_valid, b_job(), b_c1, b_cd, b_busy, b_err, b_state};
  endfunction

  // Reference job stream straight from the loop nest: oc outer, row, ic inner; CONV1 then CONV2.
  task automatic build_exp();
    int noc, nrow, nic;
    exp_q.delete();
    for (int l = 0; l < 2; l++) begin
      noc  = l ? 16 : 6;
      nrow = l ? 8 : 24;
      nic  = l ? 6 : 1;
      for (int o = 0; o < noc; o++)
        for (int r = 0; r < nrow; r++)
          for (int i = 0; i < nic; i++)
            exp_q.push_back({l[0], o[3:0], r[4:0], i[2:0], (i == 0), (i == nic - 1)});
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    out_cnt = 0; done_total = 0; exp_c1 = -1; exp_cd = -1; fire_cnt = 0;
    l0_fires = 0; l1_fires = 0; n_c1 = 0; n_cd = 0; last_due = 0;
    hold_prev = 0; seen_cd = 0; stall_left = 0;
  endtask

  task automatic start_a();
    model_clear();
    build_exp();
    start_req = 1;
  endtask

  // Observe A at the falling edge, then drive the inputs seen at the next rising edge.
  task automatic step_a(input bit rnd);
    logic [14:0] j;
    logic [14:0] e;
    bit fire;
    @(negedge clk);
    cyc++;
    j = a_job();
    if (a_c1) n_c1++;
    if (a_cd) n_cd++;
    if (a_c1 || cyc == exp_c1) check("conv1_done_pulse", a_c1, cyc == exp_c1);
    if (cyc == exp_c1) check("no_valid_at_conv1_done", a_if.job_valid, 1'b0);
    if (a_cd || cyc == exp_cd) begin
      check("conv_done_pulse", a_cd, cyc == exp_cd);
      seen_cd = seen_cd | a_cd;
    end
    if (exp_cd >= 0 && cyc == exp_cd + 1) check("busy_low_after_done", a_busy, 1'b0);
    if (hold_prev) check("hold_stable", {a_if.job_valid, j}, {1'b1, prev_job});
    if (a_if.job_valid) check("max_outstanding", out_cnt < A_MAXOUT, 1'b1);
    if (stall_arm && a_if.job_valid && l1_fires >= 100) begin
      stall_left = 10;
      stall_arm  = 0;
    end

    if (stall_left > 0) begin
      a_if.job_ready = 1'b0;
      stall_left--;
    end else begin
      a_if.job_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    a_if.job_done = spur_req || (pend_q.size() > 0 && pend_q[0] <= cyc);
    a_start = start_req;
    start_req = 0;
    if (a_if.job_done && !spur_req) begin
      void'(pend_q.pop_front());
      out_cnt--;
      done_total++;
      if (done_total == A_N1) exp_c1 = cyc + 1;
      if (done_total == A_N1 + A_N2) exp_cd = cyc + 1;
    end
    spur_req = 0;

    fire = a_if.job_valid && a_if.job_ready;
    hold_prev = a_if.job_valid && !a_if.job_ready;
    prev_job = j;
    if (fire) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7fff;
      check("job_order", j, e);
      out_cnt++;
      fire_cnt++;
      if (j[14]) l1_fires++; else l0_fires++;
      last_due = cyc + (rnd ? int'($urandom_range(1, 6)) : 3);
      if (pend_q.size() > 0 && last_due <= pend_q[pend_q.size() - 1]) last_due = pend_q[pend_q.size() - 1] + 1;
      pend_q.push_back(last_due);
    end
  endtask

  task automatic run_a(input bit rnd, input int budget);
    int n;
    n = 0;
    while (!seen_cd && n < budget) begin
      if (rnd && fire_cnt == 30 && !midstart_done) begin
        start_req = 1;
        midstart_done = 1;
      end
      step_a(rnd);
      n++;
    end
    check("run_completed", seen_cd, 1'b1);
    step_a(rnd);
    check("layer0_fires", l0_fires, A_N1);
    check("layer1_fires", l1_fires, A_N2);
    check("conv1_done_count", n_c1, 1);
    check("conv_done_count", n_cd, 1);
    check("err_clear", a_err, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic reset_pulse_a();
    @(negedge clk);
    cyc++;
    a_srstn = 0; a_start = 0; a_if.job_ready = 0; a_if.job_done = 0;
    model_clear();
    @(negedge clk);
    cyc++;
    check("rst_outputs_a", outs_a(), 22'd0);
    a_srstn = 1;
  endtask

  task automatic b_drive(input logic st, input logic rdy, input logic dn, output bit fired, output logic [14:0] j);
    @(negedge clk);
    cyc++;
    j = b_job();
    fired = b_if.job_valid && rdy;
    b_start = st;
    b_if.job_ready = rdy;
    b_if.job_done = dn;
  endtask

  task automatic tv(input int i, input int stall, input logic [14:0] e);
    tbl[i].stall = stall;
    tbl[i].exp   = e;
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    bit f, got, seen;
    logic [14:0] j;
    int pend_b, guard, nf, nf2;
    logic dn;

    //        stall  layer  oc    row   ic    first last
    tv(0, 0, {1'b0, 4'd0, 5'd0, 3'd0, 1'b1, 1'b0});
    tv(1, 0, {1'b0, 4'd0, 5'd0, 3'd1, 1'b0, 1'b1});
    tv(2, 3, {1'b0, 4'd0, 5'd1, 3'd0, 1'b1, 1'b0});
    tv(3, 0, {1'b0, 4'd0, 5'd1, 3'd1, 1'b0, 1'b1});
    tv(4, 0, {1'b0, 4'd1, 5'd0, 3'd0, 1'b1, 1'b0});
    tv(5, 2, {1'b0, 4'd1, 5'd0, 3'd1, 1'b0, 1'b1});
    tv(6, 0, {1'b0, 4'd1, 5'd1, 3'd0, 1'b1, 1'b0});
    tv(7, 0, {1'b0, 4'd1, 5'd1, 3'd1, 1'b0, 1'b1});

    a_srstn = 0; a_start = 0; a_if.job_ready = 0; a_if.job_done = 0;
    b_srstn = 0; b_start = 0; b_if.job_ready = 0; b_if.job_done = 0;
    start_req = 0; spur_req = 0; stall_arm = 0; midstart_done = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_outputs_a", outs_a(), 22'd0);
    check("rst_outputs_b", outs_b(), 22'd0);
    a_srstn = 1; b_srstn = 1;

    // A1: ready held high, completions three cycles after each fire.
    start_a();
    run_a(1'b0, 8000);

    // A2: random ready and completion delays, a stray start mid-CONV1, a 10-cycle stall mid-CONV2.
    start_a();
    stall_arm = 1;
    run_a(1'b1, 12000);
    check("stall_window_used", stall_arm, 1'b0);

    // A3: reset after 50 fires, then a clean restart from job (0,0,0).
    start_a();
    guard = 0;
    while (fire_cnt < 50 && guard < 1000) begin
      step_a(1'b1);
      guard++;
    end
    check("reached_50_fires", fire_cnt, 50);
    reset_pulse_a();
    start_a();
    run_a(1'b1, 12000);

    // A4: a completion with nothing in flight sets a sticky error.
    spur_req = 1;
    step_a(1'b0);
    step_a(1'b0);
    check("err_set", a_err, 1'b1);
    repeat (5) step_a(1'b0);
    check("err_sticky", a_err, 1'b1);
    reset_pulse_a();
    check("err_cleared_by_reset", a_err, 1'b0);

    // B1: ordering vectors through CONV1, with ready stalls before some jobs.
    pend_b = 0;
    b_drive(1'b1, 1'b0, 1'b0, f, j);
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < tbl[i].stall; s++) begin
        dn = (pend_b > 0);
        pend_b -= int'(dn);
        b_drive(1'b0, 1'b0, dn, f, j);
      end
      got = 0;
      guard = 0;
      while (!got && guard < 20) begin
        dn = (pend_b > 0);
        pend_b -= int'(dn);
        b_drive(1'b0, 1'b1, dn, f, j);
        if (f) begin
          got = 1;
          pend_b++;
          check("order", j, tbl[i].exp);
        end
        guard++;
      end
      check("order_fire_seen", got, 1'b1);
    end
    seen = 0;
    guard = 0;
    while (!seen && guard < 30) begin
      dn = (pend_b > 0);
      pend_b -= int'(dn);
      b_drive(1'b0, 1'b0, dn, f, j);
      seen = b_c1;
      guard++;
    end
    check("b_conv1_done_seen", seen, 1'b1);

    // B2: outstanding limit on CONV2 with completions withheld.
    nf = 0;
    for (int s = 0; s < 6; s++) begin
      b_drive(1'b0, 1'b1, 1'b0, f, j);
      nf += int'(f);
    end
    pend_b += nf;
    check("maxout_fires", nf, 2);
    b_drive(1'b0, 1'b0, 1'b0, f, j);
    check("maxout_valid_low", b_if.job_valid, 1'b0);
    b_drive(1'b0, 1'b0, 1'b1, f, j);
    pend_b--;
    b_drive(1'b0, 1'b0, 1'b0, f, j);
    check("reissue_after_done", b_if.job_valid, 1'b1);
    b_drive(1'b0, 1'b1, 1'b1, f, j);
    check("fire_with_done", f, 1'b1);
    b_drive(1'b0, 1'b1, 1'b0, f, j);
    check("valid_after_fire_done", f, 1'b1);
    pend_b++;
    b_drive(1'b0, 1'b0, 1'b0, f, j);
    check("valid_low_at_limit", b_if.job_valid, 1'b0);
    nf2 = 0;
    seen = 0;
    guard = 0;
    while (!seen && guard < 40) begin
      dn = (pend_b > 0);
      pend_b -= int'(dn);
      b_drive(1'b0, 1'b1, dn, f, j);
      pend_b += int'(f);
      nf2 += int'(f);
      seen = b_cd;
      guard++;
    end
    check("b_conv_done_seen", seen, 1'b1);
    check("b_layer1_fires", 4 + nf2, 6);
    b_drive(1'b0, 1'b0, 1'b0, f, j);
    check("b_busy_low_after_done", b_busy, 1'b0);
    check("b_err_clear", b_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
